uwu_uart_tx: RTL and testbench
==============================

# uwu_uart_tx

Buffered 8N1 UART transmitter on the output side of the uwuifier core: accepts bytes over a valid/ready handshake, queues them in a small synchronous FIFO, and serialises them onto the `tx` pin. The buffer absorbs the core's output expansion, since one input character can yield several output characters, so the core never stalls mid-substitution on a slow line.

## Interface
- `CLK_FREQ`, 6000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: **synchronous, active-high reset.**
- `in_data  in  8`: byte to transmit.
- `in_valid  in  1`: `in_data` valid.
- `in_ready  out  1`: FIFO can accept; `in_ready = !full`, combinational from registered pointers.
- `tx  out  1`: serial line, idle high, registered.
- `busy  out  1`: high when the FSM is not in IDLE or the FIFO is non-empty.
- `level  out  $clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- `CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD`, rounded to nearest; 52 at the defaults. Baud counter is `$clog2(CLKS_PER_BIT)` bits.
- FIFO pointers:
  - Read and write pointers are `$clog2(DEPTH)+1` bits; the MSB distinguishes full from empty.
  - `full` when the low bits are equal and the MSBs differ; `empty` when the pointers are equal.
- Push occurs on `in_valid && in_ready`. A push into a full FIFO is impossible because `in_ready` is low.
- Simultaneous push and pop: both occur and `level` is unchanged. While full, `in_ready` stays 0 even in a cycle with a pop; there is no same-cycle bypass.
- FSM states are IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE → START when `!empty`: pop the head into the shift register, clear the baud counter, set `tx` to 0.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA: shift LSB first, 8 bits, each held `CLKS_PER_BIT` cycles, with a 3-bit bit index. After bit 7, go to PARITY or STOP.
  - STOP: `tx` is 1 for `CLKS_PER_BIT` cycles. On the final count, go directly to START (popping the next byte) if `!empty`, giving no idle gap. Otherwise go to IDLE.
- `tx` always holds its value for exactly `CLKS_PER_BIT` cycles per bit.
- Reset values: `tx`=1, `busy`=0, `level`=0, `in_ready`=1, FSM in IDLE, pointers at 0.
- Reset mid-frame: the frame is aborted, `tx` goes to 1 on that edge, and FIFO contents are discarded. No partial frame is resumed.

## Timing
- Push accepted at edge E → `level` increments at E. With an idle FSM, the pop occurs and `tx` falls at E+1.
- Frame length is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity. Consecutive queued bytes are sent back-to-back.
- `busy` falls on the edge where STOP completes with the FIFO empty.

## Configuration
- `UWU_UART_TX_PARITY_EN` defined: insert an even-parity bit after data bit 7. Its value is `^data`, held `CLKS_PER_BIT` cycles (frame format 8E1).
- Undefined: the PARITY state and its logic are absent (frame format 8N1).

## Structure
- The shared package `uwu_uart_pkg` holds:
  - the `tx_state_t` enum;
  - the `clks_per_bit(CLK_FREQ, BAUD)` function, reused by the receiver.
- Sub-module `uwu_sync_fifo`: parameterised width and depth, with push/pop, full, empty and level. The FSM, shifter and baud counter live in the top module.

## Test plan
All scenarios use the defaults, so `CLKS_PER_BIT` = 52.
1. Reset held for 3 cycles → `tx`=1, `in_ready`=1, `busy`=0, `level`=0.
2. Push 0x55 at edge E →
   - `tx`=0 over [E+1, E+53);
   - data bits 1,0,1,0,1,0,1,0, each 52 cycles;
   - stop bit high;
   - `busy` low 520 cycles after E+1.
3. Push 'u' (0x75), 'w' (0x77), 'u' on 3 consecutive cycles → three frames in 1560 contiguous cycles, no idle cycle between stop and start. Receiver model decodes "uwu".
4. Hold `in_valid`=1 continuously →
   - 17 bytes accepted (the first is popped at E+1);
   - then `in_ready`=0 and `level`=16;
   - `in_ready` reasserts for exactly one push per completed frame.
5. Assert `rst` during data bit 3 of a frame with 5 bytes queued → `tx`=1 on the next edge, `level`=0, `busy`=0, no further frames.
6. With `UWU_UART_TX_PARITY_EN`, push 0x07 → parity bit 1 and frame length 572 cycles. Push 0x03 → parity bit 0.

Source files
------------

// File: rtl/uwu_uart_pkg.sv
// Shared UART types and helpers for the uwuifier serial blocks.
// UWU_UART_TX_PARITY_EN adds the PARITY state for 8E1 framing.
package uwu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UWU_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uwu_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
module uwu_sync_fifo
    import uwu_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uwu_uart_tx.sv
// Buffered UART transmitter: FIFO front end, 8N1 serialiser.
// Define UWU_UART_TX_PARITY_EN for 8E1 (even parity after bit 7).
module uwu_uart_tx
    import uwu_uart_pkg::*;
#(
    parameter int CLK_FREQ = 6000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          bit_end;
`ifdef UWU_UART_TX_PARITY_EN
    logic          par;
`endif

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign bit_end  = (cnt == CNT_MAX);
    assign pop      = !empty &&
                      ((state == IDLE) || (state == STOP && bit_end));
    assign busy     = (state != IDLE) || !empty;

    uwu_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
`ifdef UWU_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!empty) begin
                        state <= START;
                        shreg <= head;
                        tx    <= 1'b0;
`ifdef UWU_UART_TX_PARITY_EN
                        par   <= ^head;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UWU_UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UWU_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Chain straight into the next start bit: no idle gap.
                    if (bit_end) begin
                        if (!empty) begin
                            state <= START;
                            shreg <= head;
                            tx    <= 1'b0;
`ifdef UWU_UART_TX_PARITY_EN
                            par   <= ^head;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uwu_uart_tx.sv
// Scoreboard bench for uwu_uart_tx: directed pushes, line-decoding monitor.
module tb_uwu_uart_tx;

    localparam int CPB = 52;
`ifdef UWU_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [4:0] level;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_frames = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    uwu_uart_tx #(
        .CLK_FREQ (6000000),
        .BAUD     (115200),
        .DEPTH    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .level    (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Called at a negedge; returns after the accepting posedge.
    task automatic send(input logic [7:0] b, output int e);
        in_data  = b;
        in_valid = 1'b1;
        if (in_ready) exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
        e = cyc;
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("drain_busy", int'(busy), 0);
    endtask

    // Line monitor: decodes frames, checks every bit is flat for CPB cycles.
    initial begin
        logic [NB-1:0] bits;
        logic          v;
        logic          ok;
        logic          abort;
        logic [7:0]    d;
        logic [7:0]    e;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                ok    = 1'b1;
                abort = 1'b0;
                bits  = '0;
                v     = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!abort) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst) abort = 1'b1;
                            else if (c == 0) v = tx;
                            else if (tx !== v) ok = 1'b0;
                        end
                    end
                    bits[b] = v;
                end
                if (!abort) begin
                    n_frames++;
                    d = bits[8:1];
                    chk("bit_width", int'(ok), 1);
                    chk("start_bit", int'(bits[0]), 0);
                    chk("stop_bit", int'(bits[NB-1]), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", int'(d), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", int'(d), int'(e));
`ifdef UWU_UART_TX_PARITY_EN
                        chk("parity", int'(bits[9]), int'(^e));
`endif
                    end
                end
            end
        end
    end

    initial begin
        int e;
        int e0;
        int s0;
        int f0;
        int acc;
        int run;
        int max_run;
        int lows;
        logic [7:0] uwu [3];
        uwu[0] = 8'h75;
        uwu[1] = 8'h77;
        uwu[2] = 8'h75;

        // 1: reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", int'(tx), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        repeat (2) @(negedge clk);

        // 2: single 0x55 frame
        send(8'h55, e);
        chk("t2_level", int'(level), 1);
        chk("t2_tx_before", int'(tx), 1);
        @(negedge clk);
        chk("t2_tx_start", int'(tx), 0);
        chk("t2_level_pop", int'(level), 0);
        repeat (519) @(negedge clk);
        chk("t2_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("t2_busy_fall", int'(busy), 0);
        chk("t2_frames", n_frames, 1);
        repeat (10) @(negedge clk);

        // 3: "uwu" back to back
        s0 = starts.size();
        for (int i = 0; i < 3; i++) begin
            in_data  = uwu[i];
            in_valid = 1'b1;
            if (in_ready) exp_q.push_back(uwu[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle(2000);
        repeat (2) @(negedge clk);
        chk("t3_frames", starts.size() - s0, 3);
        if (starts.size() - s0 == 3) begin
            chk("t3_gap1", starts[s0+1] - starts[s0], 520);
            chk("t3_gap2", starts[s0+2] - starts[s0+1], 520);
        end

        // 4: continuous valid, FIFO fills then trickles
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data = 8'(8'hA0 + acc);
            if (!in_ready) break;
            exp_q.push_back(in_data);
            acc++;
            @(negedge clk);
        end
        chk("t4_accepted", acc, 17);
        chk("t4_level_full", int'(level), 16);
        chk("t4_ready_low", int'(in_ready), 0);
        acc = 0;
        run = 0;
        max_run = 0;
        for (int k = 0; k < 1560; k++) begin
            in_data = 8'(8'hC0 + acc);
            if (in_ready) begin
                exp_q.push_back(in_data);
                acc++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4_trickle", acc, 3);
        chk("t4_ready_pulse", max_run, 1);
        wait_idle(12000);
        chk("t4_queue_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        // 5: reset during data bit 3 with 5 bytes queued
        e0 = 0;
        for (int i = 0; i < 6; i++) begin
            in_data  = 8'(8'h10 + i);
            in_valid = 1'b1;
            if (in_ready) exp_q.push_back(in_data);
            @(negedge clk);
            if (i == 0) e0 = cyc;
        end
        in_valid = 1'b0;
        chk("t5_level", int'(level), 5);
        while (cyc < e0 + 1 + 4 * CPB + 20) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_tx", int'(tx), 1);
        chk("t5_level", int'(level), 0);
        chk("t5_busy", int'(busy), 0);
        rst = 1'b0;
        f0 = n_frames;
        lows = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("t5_line_quiet", lows, 0);
        chk("t5_no_frames", n_frames - f0, 0);

`ifdef UWU_UART_TX_PARITY_EN
        // 6: parity frames
        send(8'h07, e);
        repeat (572) @(negedge clk);
        chk("t6_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("t6_busy_fall", int'(busy), 0);
        repeat (5) @(negedge clk);
        send(8'h03, e);
        wait_idle(1000);
        repeat (2) @(negedge clk);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
